// File: rtl/pipe_stream_sink.sv
// Valid/ready stream sink: programmable backpressure, incrementing-sequence data check.
// Optional valid/data-hold protocol checker enabled by defining PIPE_SINK_PROTO_CHK_EN.
module pipe_stream_sink #(
  parameter int unsigned DW        = 8,
  parameter int unsigned CW        = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic          Clk,
  input  logic          Rstn,
  input  logic [DW-1:0] DataIn,
  input  logic          DataInVld,
  output logic          DataInRdy,
  input  logic          Start,
  input  logic [CW-1:0] BeatNum,
  input  logic [1:0]    RdyMode,
  input  logic [DW-1:0] ExpSeed,
  output logic          Busy,
  output logic          Done,
  output logic [CW-1:0] BeatCnt,
  output logic [CW-1:0] ErrCnt,
  output logic          ProtoErr,
  output logic [DW-1:0] LastData
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          rdy_q, rdy_d;
  logic          tog_q, tog_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [1:0]    mode_q, mode_d;
  logic [CW-1:0] num_q, num_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [CW-1:0] err_q, err_d;
  logic [DW-1:0] last_q, last_d;
  logic [DW-1:0] exp_q, exp_d;
  logic          hs;
  logic          start_acc;
  logic          pat;

  assign hs        = DataInVld & rdy_q;
  assign start_acc = (state_q == S_IDLE) & Start;

  always_comb begin
    state_d = state_q;
    tog_d   = tog_q;
    lfsr_d  = lfsr_q;
    mode_d  = mode_q;
    num_d   = num_q;
    beat_d  = beat_q;
    err_d   = err_q;
    last_d  = last_q;
    exp_d   = exp_q;
    pat     = 1'b0;
    rdy_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          beat_d  = '0;
          err_d   = '0;
          exp_d   = ExpSeed;
          lfsr_d  = LFSR_SEED;
          mode_d  = RdyMode;
          num_d   = BeatNum;
          tog_d   = 1'b1;
          state_d = (BeatNum != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        tog_d  = ~tog_q;
        if (hs) begin
          beat_d = beat_q + 1'b1;
          last_d = DataIn;
          if ((DataIn != exp_q) && (err_q != '1)) err_d = err_q + 1'b1;
          exp_d = exp_q + 1'b1;
          if (beat_d == num_q) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Pattern is evaluated on the next-cycle mode/LFSR/toggle so the registered
    // ready lines up with the first RUN cycle right after Start.
    case (mode_d)
      2'd0:    pat = 1'b1;
      2'd1:    pat = tog_d;
      2'd2:    pat = lfsr_d[0];
      default: pat = 1'b0;
    endcase
    rdy_d = (state_d == S_RUN) & pat;
  end

  always_ff @(posedge Clk) begin
    if (!Rstn) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      tog_q   <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      mode_q  <= '0;
      num_q   <= '0;
      beat_q  <= '0;
      err_q   <= '0;
      last_q  <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      tog_q   <= tog_d;
      lfsr_q  <= lfsr_d;
      mode_q  <= mode_d;
      num_q   <= num_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      last_q  <= last_d;
      exp_q   <= exp_d;
    end
  end

`ifdef PIPE_SINK_PROTO_CHK_EN
  logic          stall_q, stall_d;
  logic [DW-1:0] stall_data_q, stall_data_d;
  logic          proto_q, proto_d;

  always_comb begin
    stall_d      = stall_q;
    stall_data_d = stall_data_q;
    proto_d      = proto_q;
    if (start_acc) begin
      stall_d = 1'b0;
      proto_d = 1'b0;
    end else begin
      if (stall_q && (!DataInVld || (DataIn != stall_data_q))) proto_d = 1'b1;
      stall_d      = (state_q == S_RUN) & DataInVld & ~rdy_q;
      stall_data_d = DataIn;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rstn) begin
      stall_q      <= 1'b0;
      stall_data_q <= '0;
      proto_q      <= 1'b0;
    end else begin
      stall_q      <= stall_d;
      stall_data_q <= stall_data_d;
      proto_q      <= proto_d;
    end
  end

  assign ProtoErr = proto_q;
`else
  assign ProtoErr = 1'b0;
`endif

  assign DataInRdy = rdy_q;
  assign Busy      = (state_q == S_RUN);
  assign Done      = (state_q == S_DONE);
  assign BeatCnt   = beat_q;
  assign ErrCnt    = err_q;
  assign LastData  = last_q;

endmodule

// File: tb/tb_pipe_stream_sink.sv
// Scoreboard bench for pipe_stream_sink: directed runs, monitor checks beats and end-of-run results.
module tb_pipe_stream_sink;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          Clk = 1'b0;
  logic          Rstn = 1'b0;
  logic [DW-1:0] DataIn = '0;
  logic          DataInVld = 1'b0;
  logic          DataInRdy;
  logic          Start = 1'b0;
  logic [CW-1:0] BeatNum = '0;
  logic [1:0]    RdyMode = '0;
  logic [DW-1:0] ExpSeed = '0;
  logic          Busy, Done, ProtoErr;
  logic [CW-1:0] BeatCnt, ErrCnt;
  logic [DW-1:0] LastData;

  pipe_stream_sink #(.DW(DW), .CW(CW), .LFSR_SEED(16'hACE1)) dut (
    .Clk(Clk), .Rstn(Rstn), .DataIn(DataIn), .DataInVld(DataInVld), .DataInRdy(DataInRdy),
    .Start(Start), .BeatNum(BeatNum), .RdyMode(RdyMode), .ExpSeed(ExpSeed),
    .Busy(Busy), .Done(Done), .BeatCnt(BeatCnt), .ErrCnt(ErrCnt),
    .ProtoErr(ProtoErr), .LastData(LastData)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [CW-1:0] beats;
    logic [CW-1:0] errs;
    logic [DW-1:0] last;
    logic          proto;
  } res_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  res_t          res_q[$];
  logic [DW-1:0] dat_q[$];
  logic [DW-1:0] stim_q[$];
  bit            rdy_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rdy(input string name, input bit exp[$]);
    check({name, "_len"}, 32'(rdy_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < rdy_log.size(); i++)
      check($sformatf("%s_%0d", name, i), 32'(rdy_log[i]), 32'(exp[i]));
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  // Monitor: handshake data and end-of-run results against the scoreboard queues.
  initial begin : monitor
    res_t          r;
    logic [DW-1:0] d;
    forever begin
      @(negedge Clk);
      if (Rstn && DataInVld && DataInRdy) begin
        if (dat_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_beat: got data %0h, expected no handshake", DataIn);
        end else begin
          d = dat_q.pop_front();
          check("beat_data", 32'(DataIn), 32'(d));
        end
      end
      if (Done) begin
        if (res_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_done: got Done=1, expected 0");
        end else begin
          r = res_q.pop_front();
          check("res_beatcnt", 32'(BeatCnt), 32'(r.beats));
          check("res_errcnt", 32'(ErrCnt), 32'(r.errs));
          check("res_lastdata", 32'(LastData), 32'(r.last));
          check("res_protoerr", 32'(ProtoErr), 32'(r.proto));
        end
      end
    end
  end

  // Compliant upstream: holds each value valid until accepted.
  task automatic run(input logic [1:0] mode, input logic [CW-1:0] n, input logic [DW-1:0] seed,
                     input int budget, input bit expect_done, input res_t r);
    int cyc;
    bit rv;
    @(posedge Clk); #1;
    Start = 1'b1; BeatNum = n; RdyMode = mode; ExpSeed = seed;
    foreach (stim_q[i]) dat_q.push_back(stim_q[i]);
    if (expect_done) res_q.push_back(r);
    @(posedge Clk); #1;
    Start = 1'b0;
    check("busy_after_start", 32'(Busy), 32'd1);
    check("proto_clr_on_start", 32'(ProtoErr), 32'd0);
    rdy_log.delete();
    cyc = 0;
    while (stim_q.size() > 0 && cyc < budget) begin
      DataInVld = 1'b1; DataIn = stim_q[0];
      rv = DataInRdy;
      rdy_log.push_back(rv);
      @(posedge Clk); #1;
      cyc++;
      if (rv) void'(stim_q.pop_front());
    end
    DataInVld = 1'b0;
    if (stim_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL stream_timeout: got %0d beats left, expected 0", stim_q.size());
      stim_q.delete();
    end
  endtask

  task automatic check_end(input string name);
    check({name, "_done"}, 32'(Done), 32'd1);
    check({name, "_busy_low"}, 32'(Busy), 32'd0);
    check({name, "_rdy_low"}, 32'(DataInRdy), 32'd0);
    @(posedge Clk); #1;
    check({name, "_done_1cyc"}, 32'(Done), 32'd0);
  endtask

  initial begin : guard
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    res_t        r;
    bit          ep[$];
    logic [15:0] l;
    int          ones;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_rdy", 32'(DataInRdy), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_beatcnt", 32'(BeatCnt), 32'd0);
    check("rst_errcnt", 32'(ErrCnt), 32'd0);
    check("rst_lastdata", 32'(LastData), 32'd0);
    check("rst_protoerr", 32'(ProtoErr), 32'd0);
    Rstn = 1'b1;

    // Mode 0, 4 beats from 0x10
    stim_q = '{8'h10, 8'h11, 8'h12, 8'h13};
    r = '{beats: 16'd4, errs: 16'd0, last: 8'h13, proto: 1'b0};
    run(2'd0, 16'd4, 8'h10, 50, 1'b1, r);
    ep = '{1, 1, 1, 1};
    check_rdy("m0_rdy", ep);
    check_end("m0");

    // Mode 1, wrap FE,FF,00
    stim_q = '{8'hFE, 8'hFF, 8'h00};
    r = '{beats: 16'd3, errs: 16'd0, last: 8'h00, proto: 1'b0};
    run(2'd1, 16'd3, 8'hFE, 50, 1'b1, r);
    ep = '{1, 0, 1, 0, 1};
    check_rdy("m1_rdy", ep);
    check_end("m1");

    // Mode 0, one mismatch (7 where 2 expected)
    stim_q = '{8'h00, 8'h01, 8'h07, 8'h03, 8'h04};
    r = '{beats: 16'd5, errs: 16'd1, last: 8'h04, proto: 1'b0};
    run(2'd0, 16'd5, 8'h00, 50, 1'b1, r);
    check_end("mis");

    // Mode 2, 16 beats, LFSR-driven ready
    stim_q.delete();
    for (int i = 0; i < 16; i++) stim_q.push_back(8'(8'h20 + i));
    r = '{beats: 16'd16, errs: 16'd0, last: 8'h2F, proto: 1'b0};
    run(2'd2, 16'd16, 8'h20, 200, 1'b1, r);
    ep.delete();
    l = 16'hACE1;
    ones = 0;
    for (int i = 0; i < rdy_log.size(); i++) begin
      ep.push_back(l[0]);
      if (l[0]) ones++;
      l = lfsr_step(l);
    end
    check("m2_ones", 32'(ones), 32'd16);
    check_rdy("m2_rdy", ep);
    check_end("m2");

`ifdef PIPE_SINK_PROTO_CHK_EN
    // Mode 1, valid dropped during a stall
    begin
      bit            vv[7];
      logic [DW-1:0] dv[7];
      bit            re[7];
      vv = '{1, 1, 0, 1, 1, 1, 1};
      dv = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02};
      re = '{1, 0, 1, 0, 1, 0, 1};
      @(posedge Clk); #1;
      Start = 1'b1; BeatNum = 16'd3; RdyMode = 2'd1; ExpSeed = 8'h00;
      dat_q.push_back(8'h00); dat_q.push_back(8'h01); dat_q.push_back(8'h02);
      res_q.push_back('{beats: 16'd3, errs: 16'd0, last: 8'h02, proto: 1'b1});
      @(posedge Clk); #1;
      Start = 1'b0;
      for (int i = 0; i < 7; i++) begin
        DataInVld = vv[i]; DataIn = dv[i];
        check($sformatf("pe_rdy_%0d", i), 32'(DataInRdy), 32'(re[i]));
        @(posedge Clk); #1;
        if (i == 2) check("pe_set", 32'(ProtoErr), 32'd1);
      end
      DataInVld = 1'b0;
      check_end("pe");
      check("pe_sticky", 32'(ProtoErr), 32'd1);
    end
`endif

    // Mode 0, 8 beats requested, reset after 3
    stim_q = '{8'h00, 8'h01, 8'h02};
    r = '{beats: 16'd0, errs: 16'd0, last: 8'h00, proto: 1'b0};
    run(2'd0, 16'd8, 8'h00, 50, 1'b0, r);
    check("abort_beatcnt", 32'(BeatCnt), 32'd3);
    check("abort_busy", 32'(Busy), 32'd1);
    Rstn = 1'b0;
    @(posedge Clk); #1;
    Rstn = 1'b1;
    check("abort_rdy", 32'(DataInRdy), 32'd0);
    check("abort_busy_low", 32'(Busy), 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    check("abort_beatcnt_rst", 32'(BeatCnt), 32'd0);
    check("abort_lastdata", 32'(LastData), 32'd0);
    check("abort_errcnt", 32'(ErrCnt), 32'd0);

    // BeatNum = 0: straight to DONE
    @(posedge Clk); #1;
    Start = 1'b1; BeatNum = 16'd0; RdyMode = 2'd0; ExpSeed = 8'h00;
    res_q.push_back('{beats: 16'd0, errs: 16'd0, last: 8'h00, proto: 1'b0});
    @(posedge Clk); #1;
    Start = 1'b0;
    check("zero_done", 32'(Done), 32'd1);
    check("zero_busy", 32'(Busy), 32'd0);
    check("zero_rdy", 32'(DataInRdy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      check($sformatf("zero_rdy_after_%0d", i), 32'(DataInRdy), 32'd0);
      check($sformatf("zero_done_after_%0d", i), 32'(Done), 32'd0);
    end

    repeat (2) @(posedge Clk);
    #1;
    check("sb_res_empty", 32'(res_q.size()), 32'd0);
    check("sb_dat_empty", 32'(dat_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
